// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and widths for register-style responders.
// No logic; width helper only.
package ahb_pkg;

    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } slv_state_e;

    // Register index width; a single-register bank still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_intf.sv
// AHB-Lite bus bundle between one initiator and one responder.
// No logic; hready is the only backpressure signal.
interface ahb_intf;
    import ahb_pkg::*;

    logic              hsel;
    logic [AHB_AW-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [3:0]        hprot;
    logic [AHB_DW-1:0] hwdata;
    logic [AHB_DW-1:0] hrdata;
    logic              hready;
    logic [1:0]        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hprot, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_addr_decode.sv
// Byte address to register index decode with range and alignment check.
// Latency: combinational. Backpressure: none.
module ahb_addr_decode
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 16,
    parameter int          IDX_W     = idx_w(NUM_REGS)
) (
    input  logic [AHB_AW-1:0] haddr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    logic [31:0] off;

    // Full-width compare before truncation so high offsets never alias.
    assign off   = haddr - BASE_ADDR;
    assign valid = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < 32'(NUM_REGS));
    assign idx   = off[2 +: IDX_W];

endmodule

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite register bank responder with programmable wait states and ERROR response.
// Latency: WAIT_STATES low cycles then one DONE cycle; errors take two cycles. Stalls via hready.
module ahb_slave_regfile
    import ahb_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic   hclk,
    input  logic   hrst_n,
    ahb_intf.slave bus
);

    localparam int IW = idx_w(NUM_REGS);

    slv_state_e        state, nstate;
    logic [3:0]        cnt, cnt_nxt;
    logic              dec_valid;
    logic [IW-1:0]     dec_idx;
    logic              lat_wr;
    logic [IW-1:0]     lat_idx;
    logic              ready_c;
    logic              accept;
    logic              rd_wr;
    logic [IW-1:0]     rd_idx;
    logic [AHB_DW-1:0] regs [NUM_REGS];
    logic [AHB_DW-1:0] rdata_q;
    logic              unused_bits;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IW)
    ) u_decode (
        .haddr (bus.haddr),
        .valid (dec_valid),
        .idx   (dec_idx)
    );

    assign ready_c     = (state != S_WAIT) && (state != S_ERR1);
    assign accept      = bus.hsel && bus.htrans[1] && ready_c;
    assign bus.hready  = ready_c;
    assign bus.hresp   = (state == S_ERR1 || state == S_ERR2) ? HR_ERROR : HR_OKAY;
    assign bus.hrdata  = rdata_q;
    assign unused_bits = ^{bus.hprot, bus.htrans[0]};

    // With zero wait states a new transfer reaches DONE straight from its address phase.
    assign rd_wr  = accept ? bus.hwrite : lat_wr;
    assign rd_idx = accept ? dec_idx    : lat_idx;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nstate;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nstate  = state;
        cnt_nxt = cnt;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                nstate = S_IDLE;
                if (accept) begin
                    if (!dec_valid) begin
                        nstate = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        nstate  = S_WAIT;
                        cnt_nxt = 4'(WAIT_STATES - 1);
                    end else begin
                        nstate = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) nstate = S_DONE;
                else             cnt_nxt = cnt - 4'd1;
            end
            S_ERR1:  nstate = S_ERR2;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            lat_wr  <= 1'b0;
            lat_idx <= '0;
        end else if (accept) begin
            lat_wr  <= bus.hwrite;
            lat_idx <= dec_idx;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            rdata_q <= '0;
        end else begin
            if (state == S_DONE && lat_wr) regs[lat_idx] <= bus.hwdata;
            // A read landing on the same edge as a committing write sees the new data.
            if (nstate == S_DONE && !rd_wr) begin
                if (state == S_DONE && lat_wr && lat_idx == rd_idx) rdata_q <= bus.hwdata;
                else                                                rdata_q <= regs[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one initiator; sel picks the target.
module tb_ahb_slave_regfile;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hrst_n;
    int          sel;
    logic        hsel, hwrite;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic [31:0] haddr, hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    ahb_intf bus_ws1 ();
    ahb_intf bus_ws0 ();
    ahb_intf bus_ws3 ();

    assign bus_ws1.hsel = hsel && (sel == 0);
    assign bus_ws0.hsel = hsel && (sel == 1);
    assign bus_ws3.hsel = hsel && (sel == 2);
    assign {bus_ws1.haddr, bus_ws1.htrans, bus_ws1.hwrite, bus_ws1.hprot, bus_ws1.hwdata} = {haddr, htrans, hwrite, hprot, hwdata};
    assign {bus_ws0.haddr, bus_ws0.htrans, bus_ws0.hwrite, bus_ws0.hprot, bus_ws0.hwdata} = {haddr, htrans, hwrite, hprot, hwdata};
    assign {bus_ws3.haddr, bus_ws3.htrans, bus_ws3.hwrite, bus_ws3.hprot, bus_ws3.hwdata} = {haddr, htrans, hwrite, hprot, hwdata};

    assign hready = (sel == 0) ? bus_ws1.hready : (sel == 1) ? bus_ws0.hready : bus_ws3.hready;
    assign hresp  = (sel == 0) ? bus_ws1.hresp  : (sel == 1) ? bus_ws0.hresp  : bus_ws3.hresp;
    assign hrdata = (sel == 0) ? bus_ws1.hrdata : (sel == 1) ? bus_ws0.hrdata : bus_ws3.hrdata;

    ahb_slave_regfile #(.WAIT_STATES(1)) u_ws1 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus_ws1.slave));
    ahb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus_ws0.slave));
    ahb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus_ws3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = HT_IDLE;
        hwrite = 1'b0;
        haddr  = 32'h0;
    endtask

    // Starts just after a rising edge, returns just after the edge ending the final data cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int low, output logic [1:0] resp_low,
                        output logic [1:0] resp_end, output logic [31:0] rdata);
        bit done = 1'b0;
        low = 0; resp_low = 2'b00; resp_end = 2'b11; rdata = 32'hx;
        hsel = 1'b1; htrans = HT_NONSEQ; hwrite = wr; haddr = addr;
        @(posedge hclk); #1;
        idle_bus();
        hwdata = 32'h0BAD_0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge hclk);
            if (hready) begin
                resp_end = hresp;
                rdata    = hrdata;
                if (wr) hwdata = wdata;
                done = 1'b1;
                break;
            end
            if (low == 0) resp_low = hresp;
            low++;
            hwdata = 32'h0BAD_0000 + 32'(low);
        end
        if (!done) check("xfer_timeout", 32'(done), 32'd1);
        @(posedge hclk); #1;
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data, input int exp_low);
        int low; logic [1:0] rl, re; logic [31:0] rd;
        xfer(1'b1, addr, data, low, rl, re, rd);
        check({tag, "_low"}, 32'(low), 32'(exp_low));
        check({tag, "_resp"}, 32'(re), 32'(HR_OKAY));
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp, input int exp_low);
        int low; logic [1:0] rl, re; logic [31:0] rd;
        xfer(1'b0, addr, 32'h0, low, rl, re, rd);
        check({tag, "_low"}, 32'(low), 32'(exp_low));
        check({tag, "_resp"}, 32'(re), 32'(HR_OKAY));
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [31:0] addr);
        int low; logic [1:0] rl, re; logic [31:0] rd;
        xfer(wr, addr, 32'h0000_0001, low, rl, re, rd);
        check({tag, "_low"}, 32'(low), 32'd1);
        check({tag, "_resp1"}, 32'(rl), 32'(HR_ERROR));
        check({tag, "_resp2"}, 32'(re), 32'(HR_ERROR));
        @(negedge hclk);
        check({tag, "_resp_after"}, 32'(hresp), 32'(HR_OKAY));
        check({tag, "_rdy_after"}, 32'(hready), 32'd1);
        @(posedge hclk); #1;
    endtask

    typedef struct {
        logic        sel_b;
        logic [1:0]  trans;
        logic [31:0] addr;
    } quiet_t;

    quiet_t quiet [4];

    initial begin
        quiet[0] = '{1'b1, HT_BUSY,   32'h10};
        quiet[1] = '{1'b0, HT_NONSEQ, 32'h10};
        quiet[2] = '{1'b0, HT_SEQ,    32'h4};
        quiet[3] = '{1'b1, HT_IDLE,   32'h40};

        hrst_n = 1'b0; sel = 0; hprot = 4'h3; hwdata = 32'h0;
        idle_bus();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("reset_hready", 32'(hready), 32'd1);
            check("reset_hresp", 32'(hresp), 32'(HR_OKAY));
            check("reset_hrdata", hrdata, 32'h0);
        end
        sel = 0;
        repeat (2) @(posedge hclk);
        @(negedge hclk); hrst_n = 1'b1;
        @(posedge hclk); #1;

        // One wait state: basic write/read, errors, no aliasing.
        wr_chk("ws1_wr4", 32'h4, 32'hDEAD_BEEF, 1);
        rd_chk("ws1_rd4", 32'h4, 32'hDEAD_BEEF, 1);
        err_chk("err_range", 1'b0, 32'h40);
        check("err_keeps_hrdata", hrdata, 32'hDEAD_BEEF);
        err_chk("err_misalign", 1'b0, 32'h6);
        err_chk("err_alias_wr", 1'b1, 32'h44);
        rd_chk("no_alias", 32'h4, 32'hDEAD_BEEF, 1);

        // Non-transfers must not disturb anything.
        wr_chk("ws1_wr10", 32'h10, 32'h0000_600D, 1);
        rd_chk("ws1_rd10", 32'h10, 32'h0000_600D, 1);
        hwrite = 1'b1; hwdata = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            hsel = quiet[i].sel_b; htrans = quiet[i].trans; haddr = quiet[i].addr;
            @(negedge hclk);
            check("quiet_hready", 32'(hready), 32'd1);
            check("quiet_hresp", 32'(hresp), 32'(HR_OKAY));
            @(posedge hclk); #1;
        end
        idle_bus();
        @(negedge hclk);
        check("quiet_hready_end", 32'(hready), 32'd1);
        check("quiet_hrdata", hrdata, 32'h0000_600D);
        @(posedge hclk); #1;
        rd_chk("quiet_rd10", 32'h10, 32'h0000_600D, 1);

        // Zero wait states: back-to-back write then read of the same register.
        sel = 1; #1;
        wr_chk("ws0_wr8_old", 32'h8, 32'h0000_5555, 0);
        hsel = 1'b1; htrans = HT_NONSEQ; hwrite = 1'b1; haddr = 32'h8;
        @(posedge hclk); #1;
        hwdata = 32'h0000_1234; hwrite = 1'b0;
        @(negedge hclk);
        check("b2b_wr_hready", 32'(hready), 32'd1);
        @(posedge hclk); #1;
        idle_bus(); hwdata = 32'h0BAD_0BAD;
        @(negedge hclk);
        check("b2b_rd_hready", 32'(hready), 32'd1);
        check("b2b_bypass", hrdata, 32'h0000_1234);
        @(posedge hclk); #1;
        rd_chk("ws0_rd8", 32'h8, 32'h0000_1234, 0);

        // Three wait states with hwdata churning until DONE.
        sel = 2; #1;
        wr_chk("ws3_wr14", 32'h14, 32'hA5A5_A5A5, 3);
        rd_chk("ws3_rd14", 32'h14, 32'hA5A5_A5A5, 3);

        // Reset in the middle of a write's wait states.
        wr_chk("ws3_wrC", 32'hC, 32'h0000_0077, 3);
        rd_chk("ws3_rdC", 32'hC, 32'h0000_0077, 3);
        hsel = 1'b1; htrans = HT_NONSEQ; hwrite = 1'b1; haddr = 32'hC;
        @(posedge hclk); #1;
        idle_bus(); hwdata = 32'hFFFF_FFFF;
        @(negedge hclk);
        check("rst_mid_wait_low", 32'(hready), 32'd0);
        #1 hrst_n = 1'b0;
        #1;
        check("rst_async_hready", 32'(hready), 32'd1);
        check("rst_async_hresp", 32'(hresp), 32'(HR_OKAY));
        check("rst_async_hrdata", hrdata, 32'h0);
        @(posedge hclk);
        @(negedge hclk); hrst_n = 1'b1;
        @(posedge hclk); #1;
        rd_chk("rst_rdC", 32'hC, 32'h0, 3);
        sel = 0; #1;
        rd_chk("rst_ws1_rd4", 32'h4, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_slave_regfile.md
Name: ahb_slave_regfile

Overview:
- AHB-Lite responder: a bank of NUM_REGS 32-bit registers answering single NONSEQ/SEQ transfers issued by the bench-side AHB initiator.
- Inserts a programmable number of wait states on every transfer.
- Returns the two-cycle ERROR response for out-of-range or misaligned addresses.
- Serves as the DUT-side target on ahb_intf for initiator-task and UVM-driver bring-up.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..256)
- WAIT_STATES, 1, hready-low cycles per OKAY transfer (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of register 0
- RESET_VAL, 32'h0, reset value of every register

Ports:
- hclk  input  1  AHB clock, rising edge
- hrst_n  input  1  asynchronous active-low reset
- hsel  input  1  slave select (address phase)
- haddr  input  32  byte address
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  input  1  1 write, 0 read
- hprot  input  4  protection; ignored
- hwdata  input  32  write data (data phase)
- hrdata  output  32  read data
- hready  output  1  transfer done / slave ready
- hresp  output  2  00 OKAY, 01 ERROR

Behaviour:
- One clock, hclk. Reset is asynchronous and active-low on hrst_n.
- Reset values (asynchronous, hrst_n=0): hready=1, hresp=00, hrdata=0, all regs=RESET_VAL, FSM=IDLE, wait counter=0.
- Address-phase accept: a transfer is accepted on a rising edge with hsel=1, htrans[1]=1 and hready=1.
  - Latch haddr, hwrite and the decode result.
  - IDLE/BUSY, or hsel=0, is no transfer; hready stays 1 and hresp stays 00.
- Decode:
  - off = haddr - BASE_ADDR (32-bit wrap).
  - valid = (off[1:0]==0) && (off[31:2] < NUM_REGS).
  - idx = off[2+$clog2(NUM_REGS)-1:2].
- FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE: on accept, go to ERR1 if !valid; else WAIT if WAIT_STATES>0; else DONE.
  - WAIT: hready=0, hresp=00. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to DONE.
  - DONE: hready=1, hresp=00, final data-phase cycle.
    - Write: reg[idx] <= hwdata at the end of this cycle.
    - Read: hrdata is valid throughout this cycle.
    - A new accept in this cycle goes to WAIT/DONE/ERR1 as from IDLE (back-to-back); otherwise go to IDLE.
  - ERR1: hready=0, hresp=01. Always go to ERR2.
  - ERR2: hready=1, hresp=01. No register update. A new accept follows IDLE rules; otherwise go to IDLE.
- Read data path:
  - hrdata is registered and loaded at the edge entering DONE from the latched idx.
  - hrdata holds its value until the next OKAY read completes; the bench may sample it one cycle after hready.
  - Error or write transfers leave hrdata unchanged.
- Write-to-read hazard: if a read enters DONE on the same edge that a write to the same idx commits, hrdata takes that edge's hwdata (bypass).
- hresp returns to 00 in the first cycle after ERR2 unless a new error transfer is pending.
- hwdata is sampled only in the DONE cycle, so it may change during WAIT cycles.
- Reset asserted mid-transfer: immediate return to reset values. The pending write is discarded.
- Arithmetic: all counters are unsigned. idx is truncated after the range check, so no aliasing occurs.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_e: IDLE, BUSY, NONSEQ, SEQ
  - hresp_e: OKAY, ERROR
  - slave FSM state enum
  - widths AHB_AW=32, AHB_DW=32
- Sub-module ahb_addr_decode: combinational haddr -> {valid, idx}, parameterised by BASE_ADDR and NUM_REGS. Reused by future slaves.
- The FSM and register array stay in the top module.

Test Plan:
- Reset, then write addr 0x4 data 0xDEAD_BEEF, then read 0x4. Expected: hready low exactly WAIT_STATES=1 cycle per transfer, hresp=00, read returns 0xDEAD_BEEF.
- Read addr 0x40 (NUM_REGS=16, out of range). Expected: hready=0/hresp=01 for one cycle, then hready=1/hresp=01, then hresp=00. Read addr 0x6 (misaligned) gives the same two-cycle ERROR.
- WAIT_STATES=0: back-to-back write 0x8=0x1234 then read 0x8 accepted in the write's DONE cycle. Expected: zero hready-low cycles, read returns 0x1234 via bypass.
- WAIT_STATES=3: change hwdata during WAIT cycles, final value 0xA5A5_A5A5 in DONE. Expected: 3 low cycles, register holds 0xA5A5_A5A5.
- htrans=BUSY and hsel=0 cycles with arbitrary haddr. Expected: hready stays 1, hresp=00, no register or hrdata change.
- Assert hrst_n mid-WAIT of a write to 0xC=0xFFFF_FFFF. Expected: outputs return to reset values immediately, later read 0xC returns RESET_VAL.
